// File: rtl/matrix_scan_ctrl.sv
// Five-column multiplexed display scanner with a double-buffered frame input.
// Define MATRIX_BLANK_EN to insert BLANK_CYCLES dark cycles between columns.
module matrix_scan_ctrl #(
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_valid,
    input  logic [29:0] frame_data,
    output logic        frame_ready,
    output logic [5:0]  code,
    output logic [4:0]  col_sel,
    output logic        blank,
    output logic        frame_done
);

    // One counter times both SCAN and BLANK, so it is sized for the longer one.
    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1
`ifdef MATRIX_BLANK_EN
        ,
        S_BLANK = 2'd2
`endif
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         col, col_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [29:0]        active, shadow;
    logic               shadow_full;
    logic               swap;
    logic               done_nxt;
    logic               accept;

    // Handshake: a frame transfers on a rising edge where frame_valid and
    // frame_ready are both 1; frame_ready is just the shadow-empty flop.
    assign frame_ready = !shadow_full;
    assign accept      = frame_valid && !shadow_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            col         <= 3'd0;
            cnt         <= '0;
            active      <= 30'd0;
            shadow      <= 30'd0;
            shadow_full <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            cnt        <= cnt_nxt;
            frame_done <= done_nxt;
            if (swap) begin
                active <= shadow;
            end
            // accept and swap are mutually exclusive: one needs the shadow empty, the other full
            if (accept) begin
                shadow      <= frame_data;
                shadow_full <= 1'b1;
            end else if (swap) begin
                shadow_full <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        cnt_nxt   = cnt;
        swap      = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (shadow_full) begin
                    swap      = 1'b1;
                    col_nxt   = 3'd0;
                    cnt_nxt   = '0;
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cnt == CNT_W'(PRESCALE - 1)) begin
                    cnt_nxt = '0;
`ifdef MATRIX_BLANK_EN
                    state_nxt = S_BLANK;
`else
                    if (col == 3'd4) begin
                        col_nxt  = 3'd0;
                        done_nxt = 1'b1;
                        swap     = shadow_full;
                    end else begin
                        col_nxt = col + 3'd1;
                    end
`endif
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef MATRIX_BLANK_EN
            S_BLANK: begin
                if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_SCAN;
                    if (col == 3'd4) begin
                        col_nxt  = 3'd0;
                        done_nxt = 1'b1;
                        swap     = shadow_full;
                    end else begin
                        col_nxt = col + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // In BLANK col and active are frozen, so code keeps the last column's value.
    always_comb begin
        col_sel = 5'b11111;
        blank   = 1'b1;
        code    = 6'd0;
        case (state)
            S_SCAN: begin
                col_sel = ~(5'b00001 << col);
                blank   = 1'b0;
                code    = active[6*col +: 6];
            end
`ifdef MATRIX_BLANK_EN
            S_BLANK: begin
                code = active[6*col +: 6];
            end
`endif
            default: begin
                col_sel = 5'b11111;
            end
        endcase
    end

endmodule
